sm_move_ctrl: RTL and testbench

- Motion sequencer for the stepper-motor pulse generator: accepts move commands and drives the generator's period input and enable.
- Provides a trapezoidal/triangular speed profile: ramps the period from START_PERIOD down to a target, cruises, then ramps back up before stopping.
- Counts the pulses actually emitted, using the generator's non-inverted pulse output as feedback, so that N-pulse moves stop exactly.
- Sits between the command/register interface and the pulse generator.

---
 rtl/sm_move_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_sm_move_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_move_ctrl.sv
// -----------------------------------------------------------------------------
// sm_move_ctrl
// Motion sequencer placed in front of the stepper pulse generator. It accepts
// move commands, drives the generator's period and enable, shapes a
// trapezoidal (or triangular) speed profile, and counts the pulses the
// generator actually emits so that N-pulse moves stop on the exact count.
//
// Ports
//   clk          50 MHz clock
//   rst          synchronous reset, active-high
//   cmd_valid    command strobe; accepted when cmd_valid & cmd_ready
//   cmd_ready    high only while idle
//   cmd_op       0 NOP, 1 RUN, 2 MOVE_N, 3 AUTO
//   cmd_count    pulse count for MOVE_N
//   auto_period  period used in AUTO, tracked every cycle
//   stop         level; graceful stop (immediate in AUTO)
//   pulse_in     generator pulse output (non-inverted), used as feedback
//   period_out   period sent to the generator, in clk cycles
//   drv_en       generator enable
//   busy         high whenever not idle
//   done         one-cycle pulse when a RUN or MOVE_N sequence ends
//   pulses_left  remaining pulse count of a MOVE_N
// -----------------------------------------------------------------------------
module sm_move_ctrl #(
  parameter int SIZE         = 16,
  parameter int CNT_W        = 24,
  parameter int START_PERIOD = 4000,
  parameter int MAN_PERIOD   = 2000,
  parameter int RAMP_STEP    = 500,
  parameter int MIN_PERIOD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [SIZE-1:0]  auto_period,
  input  logic             stop,
  input  logic             pulse_in,
  output logic [SIZE-1:0]  period_out,
  output logic             drv_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_AUTO
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_RUN    = 2'd1,
    OP_MOVE_N = 2'd2,
    OP_AUTO   = 2'd3
  } op_t;

  // Profile constants widened by one bit so the ramp arithmetic can neither
  // wrap below zero nor overflow above the SIZE-bit range.
  localparam logic [SIZE:0]   START_X = (SIZE+1)'(START_PERIOD);
  localparam logic [SIZE:0]   MAN_X   = (SIZE+1)'(MAN_PERIOD);
  localparam logic [SIZE:0]   RAMP_X  = (SIZE+1)'(RAMP_STEP);
  localparam logic [SIZE-1:0] START_P = SIZE'(START_PERIOD);
  localparam logic [SIZE-1:0] MIN_P   = SIZE'(MIN_PERIOD);

  // Registered state
  state_t           state_q, state_n;
  logic [SIZE-1:0]  period_q, period_n;
  logic [CNT_W-1:0] remaining_q, remaining_n;
  logic [CNT_W-1:0] ramp_q, ramp_n;       // accel steps taken, saturating
  logic             abort_q, abort_n;     // stop requested: end on the ramp, not the count
  logic             run_q, run_n;         // infinite move (RUN) rather than MOVE_N
  logic             done_q, done_n;
  logic             drv_en_q, busy_q, ready_q;
  logic             pulse_q;

  // Datapath helpers
  logic             edge_det;
  logic [SIZE:0]    period_ext, period_dec, period_inc, period_sum;
  logic [CNT_W-1:0] ramp_inc, rem_dec;
  logic [SIZE-1:0]  auto_clamped;

  assign edge_det     = pulse_in & ~pulse_q;
  assign period_ext   = {1'b0, period_q};
  assign period_sum   = period_ext + RAMP_X;
  assign period_dec   = (period_ext >= MAN_X + RAMP_X) ? period_ext - RAMP_X : MAN_X;
  assign period_inc   = (period_sum >= START_X) ? START_X : period_sum;
  assign ramp_inc     = (&ramp_q) ? ramp_q : ramp_q + 1'b1;
  assign rem_dec      = (remaining_q == '0) ? '0 : remaining_q - 1'b1;
  assign auto_clamped = (auto_period < MIN_P) ? MIN_P : auto_period;

  // NOTE: every sequential register is written with <= so all of them update
  // together from the values of the previous cycle; = here would let later
  // statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      period_q    <= START_P;
      remaining_q <= '0;
      ramp_q      <= '0;
      abort_q     <= 1'b0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      drv_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      period_q    <= period_n;
      remaining_q <= remaining_n;
      ramp_q      <= ramp_n;
      abort_q     <= abort_n;
      run_q       <= run_n;
      done_q      <= done_n;
      drv_en_q    <= (state_n != S_IDLE);
      busy_q      <= (state_n != S_IDLE);
      ready_q     <= (state_n == S_IDLE);
      pulse_q     <= pulse_in;
    end
  end

  // NOTE: each signal gets its hold/default value before the case statement,
  // so no path through the block leaves it unassigned and no latch is built.
  always_comb begin
    state_n     = state_q;
    period_n    = period_q;
    remaining_n = remaining_q;
    ramp_n      = ramp_q;
    abort_n     = abort_q;
    run_n       = run_q;
    done_n      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        period_n = START_P;
        ramp_n   = '0;
        abort_n  = 1'b0;
        if (cmd_valid && ready_q) begin
          unique case (op_t'(cmd_op))
            OP_RUN: begin
              state_n     = S_ACCEL;
              run_n       = 1'b1;
              remaining_n = '0;
            end
            OP_MOVE_N: begin
              run_n       = 1'b0;
              remaining_n = cmd_count;
              if (cmd_count == '0) done_n = 1'b1;
              else                 state_n = S_ACCEL;
            end
            OP_AUTO: begin
              state_n     = S_AUTO;
              period_n    = auto_clamped;
              remaining_n = '0;
            end
            default: ;
          endcase
        end
      end

      S_ACCEL: begin
        if (edge_det) begin
          period_n = period_dec[SIZE-1:0];
          ramp_n   = ramp_inc;
          if (!run_q) begin
            remaining_n = rem_dec;
            if (rem_dec == '0) begin
              // Single-pulse move: the only pulse has been emitted.
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else if (rem_dec <= ramp_inc) begin
              // Not enough pulses left to reach cruise: triangle profile.
              state_n = S_DECEL;
            end else if (period_dec == MAN_X) begin
              state_n = S_CRUISE;
            end
          end else if (period_dec == MAN_X) begin
            state_n = S_CRUISE;
          end
        end
      end

      S_CRUISE: begin
        if (edge_det && !run_q) begin
          remaining_n = rem_dec;
          // Start slowing when the pulses left equal the steps needed to ramp down.
          if (rem_dec == ramp_q) state_n = S_DECEL;
        end
      end

      S_DECEL: begin
        if (stop) abort_n = 1'b1;
        if (edge_det) begin
          period_n = period_inc[SIZE-1:0];
          if (!run_q) remaining_n = rem_dec;
          if (!run_q && !abort_q) begin
            if (rem_dec == '0) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end
          end else if (period_inc == START_X) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end

      S_AUTO: begin
        period_n = auto_clamped;
        if (stop) begin
          state_n  = S_IDLE;
          period_n = START_P;
        end
      end

      default: begin
        state_n  = S_IDLE;
        period_n = START_P;
      end
    endcase

    // A stop while speeding up or cruising diverts to the down-ramp after the
    // edge of this cycle (if any) has been processed by the current state.
    if (stop && (state_q == S_ACCEL || state_q == S_CRUISE) && state_n != S_IDLE) begin
      state_n = S_DECEL;
      abort_n = 1'b1;
    end
  end

  assign period_out  = period_q;
  assign drv_en      = drv_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_ready   = ready_q;
  assign pulses_left = remaining_q;

endmodule

// File: tb/tb_sm_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_move_ctrl
// Self-checking bench for sm_move_ctrl. The pulse generator is emulated with
// a compressed time base: after each rising pulse edge the bench records the
// period that was in force for that interval and compares the sequence with
// a profile model built from the ramp/cruise/ramp rules.
// -----------------------------------------------------------------------------
module tb_sm_move_ctrl;

  localparam int SIZE  = 16;
  localparam int CNT_W = 24;
  localparam int START = 4000;
  localparam int MAN   = 2000;
  localparam int RAMP  = 500;
  localparam int MINP  = 4;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd1;
  localparam logic [1:0] OP_MOVE_N = 2'd2;
  localparam logic [1:0] OP_AUTO   = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [SIZE-1:0]  auto_period;
  logic             stop;
  logic             pulse_in;
  logic [SIZE-1:0]  period_out;
  logic             drv_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_per[$];
  int exp_final;

  sm_move_ctrl #(
    .SIZE(SIZE), .CNT_W(CNT_W), .START_PERIOD(START), .MAN_PERIOD(MAN),
    .RAMP_STEP(RAMP), .MIN_PERIOD(MINP)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .auto_period(auto_period),
    .stop(stop), .pulse_in(pulse_in), .period_out(period_out),
    .drv_en(drv_en), .busy(busy), .done(done), .pulses_left(pulses_left)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Profile model for an uninterrupted MOVE_N of n pulses.
  // jc: steps needed to reach cruise; jd: step at which half the pulses are
  // spent. The shorter of the two sets the up-ramp length; the down-ramp
  // mirrors it after any cruise pulses.
  // ---------------------------------------------------------------------------
  function automatic void build_move_model(input int n);
    int jc, jd, a, cruise, p;
    exp_per.delete();
    jc = (START - MAN + RAMP - 1) / RAMP;
    jd = (n + 1) / 2;
    if (jd <= jc) begin a = jd; cruise = 0; end
    else          begin a = jc; cruise = n - 2 * jc; end
    p = START;
    for (int i = 1; i <= n; i++) begin
      exp_per.push_back(p);
      if (i <= a)               p = (p - RAMP > MAN) ? p - RAMP : MAN;
      else if (i > a + cruise)  p = (p + RAMP < START) ? p + RAMP : START;
    end
    exp_final = p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic issue(input logic [1:0] op, input int cnt);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin step(); guard++; end
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL issue_ready: cmd_ready never rose (op %0d)", op);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = CNT_W'(cnt);
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_count = '0;
  endtask

  // Low gap, then a rising edge; returns the period in force for the interval.
  task automatic pulse_rise(output int per_seen);
    repeat ($urandom_range(1, 4)) step();
    per_seen = int'(period_out);
    pulse_in = 1'b1;
    step();
  endtask

  task automatic pulse_fall();
    repeat ($urandom_range(0, 2)) step();
    pulse_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (period_out !== SIZE'(START)) begin n_fail++; $display("FAIL rst_period: got %0d want %0d", period_out, START); end
    n_checks++; if (drv_en !== 1'b0)  begin n_fail++; $display("FAIL rst_drv_en: got %b want 0", drv_en); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (pulses_left !== '0) begin n_fail++; $display("FAIL rst_left: got %0d want 0", pulses_left); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    rst = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %b want 0", busy); end
  endtask

  // Uninterrupted MOVE_N of n pulses against the profile model.
  task automatic test_move(input int n);
    int per, d0;
    d0 = done_cnt;
    build_move_model(n);
    issue(OP_MOVE_N, n);
    n_checks++; if (busy !== 1'b1 || drv_en !== 1'b1) begin n_fail++; $display("FAIL mv%0d_start: busy %b drv_en %b want 1 1", n, busy, drv_en); end
    n_checks++; if (pulses_left !== CNT_W'(n)) begin n_fail++; $display("FAIL mv%0d_left0: got %0d want %0d", n, pulses_left, n); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mv%0d_ready: got %b want 0", n, cmd_ready); end
    for (int i = 1; i <= n; i++) begin
      pulse_rise(per);
      n_checks++; if (per != exp_per[i-1]) begin n_fail++; $display("FAIL mv%0d_period[%0d]: got %0d want %0d", n, i, per, exp_per[i-1]); end
      n_checks++; if (pulses_left !== CNT_W'(n - i)) begin n_fail++; $display("FAIL mv%0d_left[%0d]: got %0d want %0d", n, i, pulses_left, n - i); end
      if (i < n) begin
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mv%0d_mid[%0d]: busy %b done %b want 1 0", n, i, busy, done); end
      end else begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mv%0d_done: got %b want 1", n, done); end
        n_checks++; if (drv_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mv%0d_end: drv_en %b busy %b want 0 0", n, drv_en, busy); end
        n_checks++; if (period_out !== SIZE'(exp_final)) begin n_fail++; $display("FAIL mv%0d_final_period: got %0d want %0d", n, period_out, exp_final); end
      end
      pulse_fall();
    end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mv%0d_done_len: got %b want 0", n, done); end
    n_checks++; if (period_out !== SIZE'(START)) begin n_fail++; $display("FAIL mv%0d_idle_period: got %0d want %0d", n, period_out, START); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL mv%0d_done_count: got %0d want 1", n, done_cnt - d0); end
  endtask

  // RUN, stop after k edges, ramp down to START.
  task automatic test_run_stop(input int k);
    int per, p, d0, guard;
    d0 = done_cnt;
    issue(OP_RUN, 0);
    for (int i = 1; i <= k; i++) begin
      p = START - (i - 1) * RAMP;
      if (p < MAN) p = MAN;
      pulse_rise(per);
      n_checks++; if (per != p) begin n_fail++; $display("FAIL run%0d_accel[%0d]: got %0d want %0d", k, i, per, p); end
      pulse_fall();
    end
    p = START - k * RAMP;
    if (p < MAN) p = MAN;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b1 || period_out !== SIZE'(p)) begin n_fail++; $display("FAIL run%0d_stop: busy %b period %0d want 1 %0d", k, busy, period_out, p); end
    guard = 0;
    do begin
      pulse_rise(per);
      n_checks++; if (per != p) begin n_fail++; $display("FAIL run%0d_decel: got %0d want %0d", k, per, p); end
      p = (p + RAMP < START) ? p + RAMP : START;
      if (p == START) begin
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL run%0d_end: done %b busy %b want 1 0", k, done, busy); end
      end else begin
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL run%0d_decel_busy: busy %b done %b want 1 0", k, busy, done); end
      end
      pulse_fall();
      guard++;
    end while (p < START && guard < 20);
    step();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL run%0d_done_count: got %0d want 1", k, done_cnt - d0); end
  endtask

  task automatic test_auto();
    int vals[6] = '{1234, 2, 0, 3, 4, 5};
    int want, per, d0;
    d0 = done_cnt;
    auto_period = 16'd1234;
    issue(OP_AUTO, 0);
    n_checks++; if (drv_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL auto_start: drv_en %b busy %b want 1 1", drv_en, busy); end
    for (int i = 0; i < 12; i++) begin
      auto_period = (i < 6) ? SIZE'(vals[i]) : SIZE'($urandom_range(0, 6000));
      want = (int'(auto_period) < MINP) ? MINP : int'(auto_period);
      step();
      n_checks++; if (period_out !== SIZE'(want)) begin n_fail++; $display("FAIL auto_period[%0d]: got %0d want %0d", i, period_out, want); end
    end
    pulse_rise(per);
    pulse_fall();
    step();
    n_checks++; if (pulses_left !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL auto_nocount: left %0d busy %b want 0 1", pulses_left, busy); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || drv_en !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL auto_stop: busy %b drv_en %b ready %b want 0 0 1", busy, drv_en, cmd_ready); end
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL auto_done: got %0d done pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_move();
    int per, d0;
    d0 = done_cnt;
    issue(OP_MOVE_N, 100);
    for (int i = 0; i < 6; i++) begin pulse_rise(per); pulse_fall(); end
    step();
    n_checks++; if (period_out !== SIZE'(MAN) || pulses_left !== CNT_W'(94)) begin n_fail++; $display("FAIL mid_cruise: period %0d left %0d want %0d 94", period_out, pulses_left, MAN); end
    // RUN while busy is dropped: the move keeps counting.
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    pulse_rise(per);
    n_checks++; if (pulses_left !== CNT_W'(93) || busy !== 1'b1) begin n_fail++; $display("FAIL busy_drop: left %0d busy %b want 93 1", pulses_left, busy); end
    pulse_fall();
    rst = 1'b1;
    step();
    n_checks++; if (drv_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: drv_en %b busy %b want 0 0", drv_en, busy); end
    n_checks++; if (period_out !== SIZE'(START)) begin n_fail++; $display("FAIL mid_rst_period: got %0d want %0d", period_out, START); end
    n_checks++; if (pulses_left !== '0) begin n_fail++; $display("FAIL mid_rst_left: got %0d want 0", pulses_left); end
    rst = 1'b0;
    step();
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL mid_rst_done: got %0d done pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_move_zero();
    int per;
    issue(OP_MOVE_N, 0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
    n_checks++; if (drv_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: drv_en %b busy %b want 0 0", drv_en, busy); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_len: got %b want 0", done); end
    pulse_rise(per);
    pulse_fall();
    step();
    n_checks++; if (drv_en !== 1'b0 || pulses_left !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_edge: drv_en %b left %0d done %b want 0 0 0", drv_en, pulses_left, done); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 0) test_move($urandom_range(1, 14));
      else                           test_run_stop($urandom_range(0, 8));
    end
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = OP_NOP;
    cmd_count   = '0;
    auto_period = '0;
    stop        = 1'b0;
    pulse_in    = 1'b0;

    test_reset();
    test_move(10);
    test_move(3);
    test_run_stop(6);
    test_auto();
    test_reset_mid_move();
    test_move_zero();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
